uart_tx_arbiter: RTL and testbench
==================================

// Module: uart_tx_arbiter
// PURPOSE
//  Shares one UART transmitter among N_REQ byte sources with round-robin arbitration.
//  Drives the transmitter's tx_start/data inputs and waits for its done tick.
//  Lets a requester hold the grant for a multi-byte burst, with a watchdog timeout.
//  Sits between the system byte producers and the UART tx block, on its baud-tick domain clock.
// PARAMETERS
//  N_REQ        4     number of requesters (2..8)
//  DBIT         8     data bits per byte; matches transmitter DBIT
//  TIMEOUT_CYC  4096  max i_clock cycles to wait for done tick before abort (>=2)
// PORTS
//  i_clock         in   1            system clock, all logic on rising edge
//  i_reset         in   1            synchronous reset, active-low (0 = reset)
//  i_req           in   N_REQ        per-requester byte-valid; hold until o_ack
//  i_data          in   N_REQ*DBIT   requester k byte at [k*DBIT +: DBIT]; stable while i_req[k]
//  i_last          in   N_REQ        requester k: this byte ends its burst
//  o_ack           out  N_REQ        one-cycle pulse: byte of requester k accepted
//  o_grant         out  N_REQ        one-hot current owner; all 0 when idle
//  o_tx_start      out  1            one-cycle start pulse to transmitter
//  o_tx_data       out  DBIT         byte to transmitter; registered, held until next load
//  i_tx_done_tick  in   1            transmitter end-of-stop-bit pulse
//  o_busy          out  1            1 in any state except IDLE
//  o_timeout       out  1            one-cycle pulse on watchdog abort
// BEHAVIOUR
//  Reset (i_reset=0 at edge): state=IDLE, o_grant=0, o_ack=0, o_tx_start=0, o_tx_data=0,
//   o_busy=0, o_timeout=0, watchdog=0, rr pointer=N_REQ-1 (requester 0 wins first).
//   Reset mid-operation aborts at once; no ack/start/timeout pulse is generated.
//  FSM states: IDLE, START, WAIT.
//  IDLE: if any i_req, pick first set bit searching ptr+1 upward, wrapping mod N_REQ.
//   Load o_grant, o_tx_data=i_data[sel], last_q=i_last[sel]; go START. Else stay.
//  START (exactly 1 cycle): o_tx_start=1, o_ack[grant]=1; watchdog=0; go WAIT.
//   Latency: i_req seen at cycle t -> o_tx_start/o_ack at cycle t+1.
//  WAIT: watchdog increments each cycle.
//   On i_tx_done_tick:
//   - if last_q=0 and i_req[grant]=1: reload o_tx_data/last_q from the same requester; go START.
//     Bytes of one burst are never interleaved.
//   - else: ptr=grant index, o_grant=0; go IDLE.
//   If watchdog reaches TIMEOUT_CYC-1 with no done tick: o_timeout=1 for one cycle,
//    ptr=grant index, o_grant=0; go IDLE. A done tick in that same cycle wins (no timeout).
//  Done tick in IDLE or START is ignored.
//  Requester dropping i_req mid-burst: grant is released at the next done tick.
//  New req from the granted source after its last byte: served only after the others (fair rr).
//  Earliest next arbitration: the cycle after return to IDLE.
//   Minimum gap between bytes of different owners is therefore 2 cycles.
//  o_ack, o_tx_start, o_timeout: never high for more than 1 consecutive cycle.
//  Watchdog width = clog2(TIMEOUT_CYC); it saturates and never wraps.
// TESTING
//  1 After reset, i_req=0001, data0=8'hA5, last0=1 -> next cycle o_tx_start=1, o_ack=0001,
//    o_tx_data=A5, o_grant=0001; done tick -> o_grant=0, o_busy=0 one cycle later.
//  2 All four requesters request at once, each with last=1 -> grant order 0,1,2,3;
//    exactly one o_ack per requester.
//  3 Requester 1 bursts 11,22,33 (last on 33) while requester 2 is pending -> o_tx_data 11,22,33
//    back-to-back per done tick, then requester 2's byte.
//  4 TIMEOUT_CYC=16, no done tick -> o_timeout pulses in the 16th WAIT cycle, grant released,
//    next request served from ptr+1.
//  5 i_reset=0 during WAIT with o_grant=0100 -> all outputs 0 next edge; request 0 wins after release.
//  6 Done tick injected in IDLE and in START -> no state change, no spurious ack/start.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin sharing of one UART transmitter among N_REQ byte sources,
// with per-requester bursts and a done-tick watchdog.
module uart_tx_arbiter #(
   parameter int N_REQ       = 4,
   parameter int DBIT        = 8,
   parameter int TIMEOUT_CYC = 4096
) (
   input  logic                    i_clock,
   input  logic                    i_reset,
   input  logic [N_REQ-1:0]        i_req,
   input  logic [N_REQ*DBIT-1:0]   i_data,
   input  logic [N_REQ-1:0]        i_last,
   output logic [N_REQ-1:0]        o_ack,
   output logic [N_REQ-1:0]        o_grant,
   output logic                    o_tx_start,
   output logic [DBIT-1:0]         o_tx_data,
   input  logic                    i_tx_done_tick,
   output logic                    o_busy,
   output logic                    o_timeout
);
   localparam int PW = $clog2(N_REQ);
   localparam int WW = $clog2(TIMEOUT_CYC);
   localparam logic [WW-1:0] WD_MAX = WW'(TIMEOUT_CYC - 1);
   typedef enum logic [1:0] {IDLE, START, WAIT} state_t;
   state_t state, state_n;
   logic [PW-1:0] ptr, ptr_n, gidx, gidx_n, sel, k;
   logic found;
   logic [WW-1:0] wd, wd_n;
   logic last_q, last_n;
   logic [DBIT-1:0] data_n;
   logic [N_REQ-1:0] grant_n;
   // scan downward so the nearest set bit after ptr is the one that sticks
   always_comb begin
      sel = '0;
      found = 1'b0;
      k = '0;
      for (int i = N_REQ; i >= 1; i--) begin
         k = PW'((int'(ptr) + i) % N_REQ);
         if (i_req[k]) begin
            sel = k;
            found = 1'b1;
         end
      end
   end
   always_comb begin
      state_n = state;
      ptr_n = ptr;
      gidx_n = gidx;
      grant_n = o_grant;
      data_n = o_tx_data;
      last_n = last_q;
      wd_n = wd;
      o_tx_start = 1'b0;
      o_ack = '0;
      o_timeout = 1'b0;
      o_busy = state != IDLE;
      case (state)
         IDLE: if (found) begin
            gidx_n = sel;
            grant_n = N_REQ'(1) << sel;
            data_n = i_data[sel*DBIT +: DBIT];
            last_n = i_last[sel];
            state_n = START;
         end
         START: begin
            o_tx_start = 1'b1;
            o_ack = o_grant;
            wd_n = '0;
            state_n = WAIT;
         end
         WAIT: begin
            wd_n = (wd == WD_MAX) ? wd : wd + 1'b1;
            if (i_tx_done_tick) begin
               if (!last_q && i_req[gidx]) begin
                  data_n = i_data[gidx*DBIT +: DBIT];
                  last_n = i_last[gidx];
                  state_n = START;
               end else begin
                  ptr_n = gidx;
                  grant_n = '0;
                  state_n = IDLE;
               end
            end else if (wd == WD_MAX) begin
               o_timeout = 1'b1;
               ptr_n = gidx;
               grant_n = '0;
               state_n = IDLE;
            end
         end
         default: state_n = IDLE;
      endcase
   end
   always_ff @(posedge i_clock) begin
      if (!i_reset) begin
         state <= IDLE;
         ptr <= PW'(N_REQ - 1);
         gidx <= '0;
         o_grant <= '0;
         o_tx_data <= '0;
         last_q <= 1'b0;
         wd <= '0;
      end else begin
         state <= state_n;
         ptr <= ptr_n;
         gidx <= gidx_n;
         o_grant <= grant_n;
         o_tx_data <= data_n;
         last_q <= last_n;
         wd <= wd_n;
      end
   end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed scenarios for uart_tx_arbiter, checked every cycle against a
// transaction-level model of owner / pending-start / wait-age plus literal expectations.
module tb_uart_tx_arbiter;
   localparam int TO = 16;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic [3:0] req = '0;
   logic [31:0] data = '0;
   logic [3:0] last = '0;
   logic done = 1'b0;
   logic [3:0] o_ack, o_grant;
   logic o_tx_start, o_busy, o_timeout;
   logic [7:0] o_tx_data;
   int checks = 0;
   int failures = 0;
   bit chk_en = 1'b0;
   logic [7:0] data_log[$];
   logic [3:0] ack_log[$];
   int m_owner, m_age, m_ptr, j, n;
   bit m_pulse, m_last;
   logic [7:0] m_data;

   uart_tx_arbiter #(.N_REQ(4), .DBIT(8), .TIMEOUT_CYC(TO)) dut (
      .i_clock(clk), .i_reset(rst_n), .i_req(req), .i_data(data), .i_last(last),
      .o_ack(o_ack), .o_grant(o_grant), .o_tx_start(o_tx_start), .o_tx_data(o_tx_data),
      .i_tx_done_tick(done), .o_busy(o_busy), .o_timeout(o_timeout)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // model: owner<0 means idle; pulse marks the cycle a byte is handed over; age counts wait cycles
   always @(posedge clk) begin
      if (!rst_n) begin
         m_owner = -1; m_pulse = 0; m_age = 0; m_ptr = 3; m_data = 0; m_last = 0;
      end else if (m_owner < 0) begin
         for (int i = 1; i <= 4; i++) begin
            j = (m_ptr + i) % 4;
            if (m_owner < 0 && req[j]) begin
               m_owner = j; m_data = data[j*8 +: 8]; m_last = last[j]; m_pulse = 1;
            end
         end
      end else if (m_pulse) begin
         m_pulse = 0; m_age = 0;
      end else if (done) begin
         if (!m_last && req[m_owner]) begin
            m_data = data[m_owner*8 +: 8]; m_last = last[m_owner]; m_pulse = 1;
         end else begin
            m_ptr = m_owner; m_owner = -1;
         end
      end else if (m_age == TO - 1) begin
         m_ptr = m_owner; m_owner = -1;
      end else m_age++;
   end

   always @(negedge clk) if (chk_en) begin
      chk("grant", 32'(o_grant), m_owner >= 0 ? 32'd1 << m_owner : 32'd0);
      chk("ack", 32'(o_ack), m_pulse ? 32'd1 << m_owner : 32'd0);
      chk("tx_start", 32'(o_tx_start), 32'(m_pulse));
      chk("tx_data", 32'(o_tx_data), 32'(m_data));
      chk("busy", 32'(o_busy), 32'(m_owner >= 0));
      chk("timeout", 32'(o_timeout), 32'(m_owner >= 0 && !m_pulse && m_age == TO - 1 && !done));
      if (o_tx_start) begin
         data_log.push_back(o_tx_data);
         ack_log.push_back(o_ack);
      end
   end

   task automatic tick(input int c);
      repeat (c) @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 0; req = 0; last = 0; data = 0; done = 0;
      tick(2);
      rst_n = 1;
      data_log.delete();
      ack_log.delete();
   endtask

   task automatic set_byte(input int r, input logic [7:0] b, input bit l);
      data[r*8 +: 8] = b;
      last[r] = l;
   endtask

   task automatic await_start();
      int c = 0;
      while (!o_tx_start && c < 40) begin
         tick(1);
         c++;
      end
      chk("start_seen", 32'(o_tx_start), 32'd1);
   endtask

   task automatic finish_byte(input int gap);
      tick(gap);
      done = 1;
      tick(1);
      done = 0;
   endtask

   initial begin
      tick(1);
      chk_en = 1;
      // 1: single byte after reset
      do_reset();
      chk("reset_grant", 32'(o_grant), 32'd0);
      chk("reset_busy", 32'(o_busy), 32'd0);
      set_byte(0, 8'hA5, 1);
      req = 4'b0001;
      tick(1);
      chk("t1_start", 32'(o_tx_start), 32'd1);
      chk("t1_ack", 32'(o_ack), 32'b0001);
      chk("t1_data", 32'(o_tx_data), 32'hA5);
      chk("t1_grant", 32'(o_grant), 32'b0001);
      req = 0;
      finish_byte(2);
      chk("t1_rel_grant", 32'(o_grant), 32'd0);
      chk("t1_rel_busy", 32'(o_busy), 32'd0);
      // 2: all four at once -> 0,1,2,3
      do_reset();
      for (int r = 0; r < 4; r++) set_byte(r, 8'(8'h10 + r), 1);
      req = 4'b1111;
      for (int r = 0; r < 4; r++) begin
         await_start();
         req = req & ~o_ack;
         finish_byte(1);
      end
      tick(3);
      chk("t2_count", 32'(ack_log.size()), 32'd4);
      for (int r = 0; r < 4 && r < ack_log.size(); r++) chk("t2_order", 32'(ack_log[r]), 32'd1 << r);
      // 3: burst 11,22,33 from requester 1 with requester 2 pending
      do_reset();
      set_byte(1, 8'h11, 0);
      set_byte(2, 8'h44, 1);
      req = 4'b0110;
      await_start();
      set_byte(1, 8'h22, 0);
      finish_byte(2);
      await_start();
      set_byte(1, 8'h33, 1);
      finish_byte(2);
      await_start();
      req[1] = 0;
      finish_byte(2);
      await_start();
      req[2] = 0;
      finish_byte(1);
      chk("t3_count", 32'(data_log.size()), 32'd4);
      if (data_log.size() == 4) begin
         chk("t3_b0", 32'(data_log[0]), 32'h11);
         chk("t3_b1", 32'(data_log[1]), 32'h22);
         chk("t3_b2", 32'(data_log[2]), 32'h33);
         chk("t3_b3", 32'(data_log[3]), 32'h44);
         chk("t3_owner3", 32'(ack_log[3]), 32'b0100);
      end
      // 4: watchdog timeout in the 16th wait cycle, then rr continues from ptr+1
      do_reset();
      set_byte(0, 8'h5A, 1);
      req = 4'b0001;
      await_start();
      req = 0;
      tick(1);
      n = 1;
      while (!o_timeout && n < 20) begin
         tick(1);
         n++;
      end
      chk("t4_timeout_cycle", 32'(n), 32'd16);
      tick(1);
      chk("t4_rel_grant", 32'(o_grant), 32'd0);
      set_byte(0, 8'h01, 1);
      set_byte(1, 8'h02, 1);
      req = 4'b0011;
      await_start();
      chk("t4_next_ack", 32'(o_ack), 32'b0010);
      req = req & ~o_ack;
      finish_byte(1);
      await_start();
      chk("t4_then_ack", 32'(o_ack), 32'b0001);
      req = 0;
      finish_byte(1);
      // 5: reset during WAIT
      do_reset();
      set_byte(2, 8'h77, 1);
      req = 4'b0100;
      await_start();
      req = 0;
      tick(2);
      chk("t5_grant_wait", 32'(o_grant), 32'b0100);
      rst_n = 0;
      set_byte(0, 8'h55, 1);
      req = 4'b0101;
      tick(1);
      chk("t5_rst_grant", 32'(o_grant), 32'd0);
      chk("t5_rst_ack", 32'(o_ack), 32'd0);
      chk("t5_rst_start", 32'(o_tx_start), 32'd0);
      chk("t5_rst_busy", 32'(o_busy), 32'd0);
      chk("t5_rst_timeout", 32'(o_timeout), 32'd0);
      chk("t5_rst_data", 32'(o_tx_data), 32'd0);
      rst_n = 1;
      tick(1);
      chk("t5_first_ack", 32'(o_ack), 32'b0001);
      chk("t5_first_data", 32'(o_tx_data), 32'h55);
      req = req & ~o_ack;
      finish_byte(1);
      await_start();
      chk("t5_second_ack", 32'(o_ack), 32'b0100);
      req = 0;
      finish_byte(1);
      // 6: done ticks in IDLE and START are ignored
      do_reset();
      done = 1;
      tick(1);
      done = 0;
      chk("t6_idle_busy", 32'(o_busy), 32'd0);
      chk("t6_idle_start", 32'(o_tx_start), 32'd0);
      set_byte(3, 8'h99, 1);
      req = 4'b1000;
      tick(1);
      chk("t6_start", 32'(o_tx_start), 32'd1);
      done = 1;
      req = 0;
      tick(1);
      done = 0;
      chk("t6_wait_start", 32'(o_tx_start), 32'd0);
      chk("t6_wait_ack", 32'(o_ack), 32'd0);
      chk("t6_wait_busy", 32'(o_busy), 32'd1);
      chk("t6_wait_grant", 32'(o_grant), 32'b1000);
      finish_byte(2);
      tick(2);
      chk("t6_end_busy", 32'(o_busy), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout actual=running required=finished");
      $fatal(1, "simulation time limit");
   end
endmodule
